// File: rtl/alu_operand_stage.sv
// alu_operand_stage
// Operand-issue stage in front of the 16-bit ALU. Reads the register file,
// chooses and extends the immediate, tracks outstanding writes in a
// per-register pending scoreboard, and hands a registered bundle to the ALU
// over a valid/ready handshake.
// Ports:
//   clk, rst_n                       clock, async active-low reset
//   in_valid/in_ready                decoded-instruction handshake
//   in_op, in_rd, in_rs, in_rt       op code and register addresses
//   in_imm, in_use_imm               immediate field and in1 source select
//   out_valid/out_ready              ALU-bundle handshake
//   alu_in0, alu_in1, alu_select     registered ALU operands and op code
//   alu_rd, alu_wr                   destination and write-back flag
//   wb_en, wb_addr, wb_data          write-back port from the result path
//   flush                            discard the held bundle
module alu_operand_stage #(
   parameter int DATA_W = 16,
   parameter int REG_N  = 8,
   parameter int AW     = 3
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [3:0]        in_op,
   input  logic [AW-1:0]     in_rd,
   input  logic [AW-1:0]     in_rs,
   input  logic [AW-1:0]     in_rt,
   input  logic [7:0]        in_imm,
   input  logic              in_use_imm,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [DATA_W-1:0] alu_in0,
   output logic [DATA_W-1:0] alu_in1,
   output logic [3:0]        alu_select,
   output logic [AW-1:0]     alu_rd,
   output logic              alu_wr,
   input  logic              wb_en,
   input  logic [AW-1:0]     wb_addr,
   input  logic [DATA_W-1:0] wb_data,
   input  logic              flush
);

   logic [DATA_W-1:0] regs_q [REG_N];
   logic [REG_N-1:0]  pend_q, pend_d;
   logic              out_valid_q, out_valid_d;
   logic [DATA_W-1:0] in0_q, in1_q, in0_d, in1_d;
   logic [3:0]        sel_q;
   logic [AW-1:0]     rd_q;
   logic              wr_q;

   logic              writes_s;
   logic [REG_N-1:0]  clr_s;
   logic [REG_N-1:0]  pend_eff_s;
   logic              hazard_s;
   logic              issue_s;
   logic [DATA_W-1:0] rs_val_s, rt_val_s;

   // Hazard detection, operand selection with write-back bypass, handshake.
   always_comb begin
      writes_s = (in_op[3:2] != 2'b11) && (in_rd != {AW{1'b0}});
      clr_s    = {REG_N{1'b0}};
      if (wb_en && (wb_addr != {AW{1'b0}})) begin
         clr_s[wb_addr] = 1'b1;
      end else begin
         clr_s = {REG_N{1'b0}};
      end
      // A register being written back this cycle no longer blocks issue.
      pend_eff_s = pend_q & ~clr_s;
      hazard_s   = ((in_rs != {AW{1'b0}}) && pend_eff_s[in_rs]) ||
                   (!in_use_imm && (in_rt != {AW{1'b0}}) && pend_eff_s[in_rt]) ||
                   (writes_s && pend_eff_s[in_rd]);
      in_ready   = rst_n && !flush && !hazard_s && (!out_valid_q || out_ready);
      issue_s    = in_valid && in_ready;

      if (in_rs == {AW{1'b0}}) begin
         rs_val_s = {DATA_W{1'b0}};
      end else if (wb_en && (wb_addr == in_rs)) begin
         rs_val_s = wb_data;
      end else begin
         rs_val_s = regs_q[in_rs];
      end
      if (in_rt == {AW{1'b0}}) begin
         rt_val_s = {DATA_W{1'b0}};
      end else if (wb_en && (wb_addr == in_rt)) begin
         rt_val_s = wb_data;
      end else begin
         rt_val_s = regs_q[in_rt];
      end

      in0_d = rs_val_s;
      if (!in_use_imm) begin
         in1_d = rt_val_s;
      end else if ((in_op == 4'b0111) || (in_op == 4'b1000)) begin
         // Shift amounts are unsigned.
         in1_d = {{(DATA_W-8){1'b0}}, in_imm};
      end else begin
         in1_d = {{(DATA_W-8){in_imm[7]}}, in_imm};
      end
   end

   // Next-state of the scoreboard and the output-valid flag.
   always_comb begin
      pend_d = pend_q & ~clr_s;
      if (flush && out_valid_q && wr_q) begin
         pend_d[rd_q] = 1'b0;
      end else begin
         pend_d = pend_d;
      end
      // Applied last so a same-cycle set beats a write-back clear.
      if (issue_s && writes_s) begin
         pend_d[in_rd] = 1'b1;
      end else begin
         pend_d = pend_d;
      end

      if (flush) begin
         out_valid_d = 1'b0;
      end else if (issue_s) begin
         out_valid_d = 1'b1;
      end else if (out_ready) begin
         out_valid_d = 1'b0;
      end else begin
         out_valid_d = out_valid_q;
      end
   end

   // Register file; r0 is never written.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < REG_N; i++) begin
            regs_q[i] <= {DATA_W{1'b0}};
         end
      end else if (wb_en && (wb_addr != {AW{1'b0}})) begin
         regs_q[wb_addr] <= wb_data;
      end
   end

   // Scoreboard, valid flag and the held ALU bundle.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pend_q      <= {REG_N{1'b0}};
         out_valid_q <= 1'b0;
         in0_q       <= {DATA_W{1'b0}};
         in1_q       <= {DATA_W{1'b0}};
         sel_q       <= 4'b0000;
         rd_q        <= {AW{1'b0}};
         wr_q        <= 1'b0;
      end else begin
         pend_q      <= pend_d;
         out_valid_q <= out_valid_d;
         if (issue_s) begin
            in0_q <= in0_d;
            in1_q <= in1_d;
            sel_q <= in_op;
            rd_q  <= in_rd;
            wr_q  <= writes_s;
         end
      end
   end

   assign out_valid  = out_valid_q;
   assign alu_in0    = in0_q;
   assign alu_in1    = in1_q;
   assign alu_select = sel_q;
   assign alu_rd     = rd_q;
   assign alu_wr     = wr_q;

endmodule

// File: tb/tb_alu_operand_stage.sv
module tb_alu_operand_stage;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        in_valid;
   logic        in_ready;
   logic [3:0]  in_op;
   logic [2:0]  in_rd, in_rs, in_rt;
   logic [7:0]  in_imm;
   logic        in_use_imm;
   logic        out_valid;
   logic        out_ready;
   logic [15:0] alu_in0, alu_in1;
   logic [3:0]  alu_select;
   logic [2:0]  alu_rd;
   logic        alu_wr;
   logic        wb_en;
   logic [2:0]  wb_addr;
   logic [15:0] wb_data;
   logic        flush;

   int tests = 0;
   int fails = 0;

   alu_operand_stage dut (
      .clk(clk), .rst_n(rst_n),
      .in_valid(in_valid), .in_ready(in_ready),
      .in_op(in_op), .in_rd(in_rd), .in_rs(in_rs), .in_rt(in_rt),
      .in_imm(in_imm), .in_use_imm(in_use_imm),
      .out_valid(out_valid), .out_ready(out_ready),
      .alu_in0(alu_in0), .alu_in1(alu_in1), .alu_select(alu_select),
      .alu_rd(alu_rd), .alu_wr(alu_wr),
      .wb_en(wb_en), .wb_addr(wb_addr), .wb_data(wb_data),
      .flush(flush)
   );

   always #5 clk = ~clk;

   task automatic idle();
      in_valid = 1'b0; in_op = 4'd0; in_rd = 3'd0; in_rs = 3'd0; in_rt = 3'd0;
      in_imm = 8'd0; in_use_imm = 1'b0; wb_en = 1'b0; wb_addr = 3'd0;
      wb_data = 16'd0; flush = 1'b0;
   endtask

   task automatic instr(input logic [3:0] op, input logic [2:0] rd, input logic [2:0] rs,
                        input logic [2:0] rt, input logic [7:0] imm, input logic ui);
      in_valid = 1'b1; in_op = op; in_rd = rd; in_rs = rs; in_rt = rt;
      in_imm = imm; in_use_imm = ui;
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      idle(); out_ready = 1'b1; rst_n = 1'b0;
      #1;
      tests++;
      if (in_ready !== 1'b0) begin fails++; $display("FAIL reset_in_ready got %0b exp 0", in_ready); end
      tests++;
      if (out_valid !== 1'b0 || alu_in0 !== 16'd0 || alu_in1 !== 16'd0 || alu_wr !== 1'b0 || alu_select !== 4'd0 || alu_rd !== 3'd0) begin
         fails++; $display("FAIL reset_outputs got v=%0b in0=%h in1=%h wr=%0b sel=%h rd=%0d exp zeros", out_valid, alu_in0, alu_in1, alu_wr, alu_select, alu_rd);
      end
      step(); step();
      rst_n = 1'b1;
      step();
      tests++;
      if (in_ready !== 1'b1 || out_valid !== 1'b0) begin fails++; $display("FAIL idle got rdy=%0b v=%0b exp 1/0", in_ready, out_valid); end
      for (int i = 0; i < 8; i++) begin
         instr(4'b0000, 3'd0, 3'(i), 3'(i), 8'd0, 1'b0);
         step();
         tests++;
         if (out_valid !== 1'b1 || alu_in0 !== 16'd0 || alu_in1 !== 16'd0) begin
            fails++; $display("FAIL reset_read_r%0d got v=%0b in0=%h in1=%h exp 1/0/0", i, out_valid, alu_in0, alu_in1);
         end
      end
      idle(); step();
   endtask

   task automatic test_basic();
      wb_en = 1'b1; wb_addr = 3'd3; wb_data = 16'h1234;
      step();
      idle();
      instr(4'b0000, 3'd0, 3'd3, 3'd0, 8'd0, 1'b0);
      #1;
      tests++;
      if (in_ready !== 1'b1) begin fails++; $display("FAIL basic_ready got %0b exp 1", in_ready); end
      step();
      tests++;
      if (out_valid !== 1'b1 || alu_in0 !== 16'h1234 || alu_in1 !== 16'h0000 || alu_wr !== 1'b0) begin
         fails++; $display("FAIL basic_operands got v=%0b in0=%h in1=%h wr=%0b exp 1/1234/0000/0", out_valid, alu_in0, alu_in1, alu_wr);
      end
      idle(); step();
   endtask

   task automatic test_hazard();
      instr(4'b0000, 3'd2, 3'd0, 3'd0, 8'd0, 1'b0);
      step();
      tests++;
      if (alu_wr !== 1'b1 || alu_rd !== 3'd2) begin fails++; $display("FAIL hazard_producer got wr=%0b rd=%0d exp 1/2", alu_wr, alu_rd); end
      instr(4'b0001, 3'd0, 3'd2, 3'd0, 8'd0, 1'b0);
      #1;
      tests++;
      if (in_ready !== 1'b0) begin fails++; $display("FAIL hazard_stall1 got %0b exp 0", in_ready); end
      step();
      tests++;
      if (in_ready !== 1'b0 || out_valid !== 1'b0) begin fails++; $display("FAIL hazard_stall2 got rdy=%0b v=%0b exp 0/0", in_ready, out_valid); end
      wb_en = 1'b1; wb_addr = 3'd2; wb_data = 16'h00FF;
      #1;
      tests++;
      if (in_ready !== 1'b1) begin fails++; $display("FAIL hazard_release got %0b exp 1", in_ready); end
      step();
      tests++;
      if (out_valid !== 1'b1 || alu_in0 !== 16'h00FF || alu_select !== 4'b0001) begin
         fails++; $display("FAIL hazard_bypass got v=%0b in0=%h sel=%h exp 1/00ff/1", out_valid, alu_in0, alu_select);
      end
      idle();
      instr(4'b0010, 3'd0, 3'd2, 3'd3, 8'd0, 1'b0);
      step();
      tests++;
      if (alu_in0 !== 16'h00FF || alu_in1 !== 16'h1234) begin
         fails++; $display("FAIL regread_rs_rt got in0=%h in1=%h exp 00ff/1234", alu_in0, alu_in1);
      end
      idle(); step();
   endtask

   task automatic test_imm();
      instr(4'b0000, 3'd0, 3'd0, 3'd0, 8'h80, 1'b1);
      step();
      tests++;
      if (alu_in1 !== 16'hFF80) begin fails++; $display("FAIL imm_sext got %h exp ff80", alu_in1); end
      instr(4'b0111, 3'd0, 3'd0, 3'd0, 8'h80, 1'b1);
      step();
      tests++;
      if (alu_in1 !== 16'h0080) begin fails++; $display("FAIL imm_shl_zext got %h exp 0080", alu_in1); end
      instr(4'b1000, 3'd0, 3'd0, 3'd0, 8'hFF, 1'b1);
      step();
      tests++;
      if (alu_in1 !== 16'h00FF) begin fails++; $display("FAIL imm_shr_zext got %h exp 00ff", alu_in1); end
      // rt points at a register holding data, but the immediate must win.
      instr(4'b0011, 3'd0, 3'd0, 3'd3, 8'h05, 1'b1);
      step();
      tests++;
      if (alu_in1 !== 16'h0005) begin fails++; $display("FAIL imm_over_rt got %h exp 0005", alu_in1); end
      instr(4'b1100, 3'd4, 3'd3, 3'd0, 8'd0, 1'b0);
      step();
      tests++;
      if (alu_wr !== 1'b0 || out_valid !== 1'b1) begin fails++; $display("FAIL cmp_no_wr got wr=%0b v=%0b exp 0/1", alu_wr, out_valid); end
      // No pending bit for r4, so a writer to r4 is not a WAW stall.
      instr(4'b0000, 3'd4, 3'd0, 3'd0, 8'd0, 1'b0);
      #1;
      tests++;
      if (in_ready !== 1'b1) begin fails++; $display("FAIL cmp_no_pending got %0b exp 1", in_ready); end
      step();
      // r4 now pending: WAW writer must stall until its write-back.
      instr(4'b0001, 3'd4, 3'd0, 3'd0, 8'd0, 1'b0);
      #1;
      tests++;
      if (in_ready !== 1'b0) begin fails++; $display("FAIL waw_stall got %0b exp 0", in_ready); end
      idle();
      wb_en = 1'b1; wb_addr = 3'd4; wb_data = 16'h0000;
      step();
      idle(); step();
   endtask

   task automatic test_backpressure();
      out_ready = 1'b0;
      instr(4'b0001, 3'd0, 3'd3, 3'd2, 8'd0, 1'b0);
      step();
      instr(4'b0000, 3'd0, 3'd2, 3'd0, 8'd0, 1'b0);
      for (int i = 0; i < 3; i++) begin
         #1;
         tests++;
         if (in_ready !== 1'b0 || out_valid !== 1'b1 || alu_in0 !== 16'h1234 || alu_in1 !== 16'h00FF || alu_select !== 4'b0001) begin
            fails++; $display("FAIL bp_hold%0d got rdy=%0b v=%0b in0=%h in1=%h sel=%h exp 0/1/1234/00ff/1", i, in_ready, out_valid, alu_in0, alu_in1, alu_select);
         end
         step();
      end
      out_ready = 1'b1;
      #1;
      tests++;
      if (in_ready !== 1'b1) begin fails++; $display("FAIL bp_release got %0b exp 1", in_ready); end
      step();
      tests++;
      if (out_valid !== 1'b1 || alu_in0 !== 16'h00FF || alu_select !== 4'b0000) begin
         fails++; $display("FAIL bp_next got v=%0b in0=%h sel=%h exp 1/00ff/0", out_valid, alu_in0, alu_select);
      end
      idle(); step();
   endtask

   task automatic test_flush();
      out_ready = 1'b0;
      instr(4'b0000, 3'd5, 3'd3, 3'd0, 8'd0, 1'b0);
      step();
      tests++;
      if (out_valid !== 1'b1 || alu_wr !== 1'b1 || alu_rd !== 3'd5) begin
         fails++; $display("FAIL flush_held got v=%0b wr=%0b rd=%0d exp 1/1/5", out_valid, alu_wr, alu_rd);
      end
      instr(4'b0000, 3'd0, 3'd5, 3'd0, 8'd0, 1'b0);
      out_ready = 1'b1;
      #1;
      tests++;
      if (in_ready !== 1'b0) begin fails++; $display("FAIL flush_pre_hazard got %0b exp 0", in_ready); end
      in_valid = 1'b0; flush = 1'b1;
      #1;
      tests++;
      if (in_ready !== 1'b0) begin fails++; $display("FAIL flush_ready got %0b exp 0", in_ready); end
      step();
      tests++;
      if (out_valid !== 1'b0) begin fails++; $display("FAIL flush_valid got %0b exp 0", out_valid); end
      flush = 1'b0;
      instr(4'b0000, 3'd0, 3'd5, 3'd0, 8'd0, 1'b0);
      #1;
      tests++;
      if (in_ready !== 1'b1) begin fails++; $display("FAIL flush_pending_cleared got %0b exp 1", in_ready); end
      step();
      tests++;
      if (out_valid !== 1'b1 || alu_in0 !== 16'h0000) begin fails++; $display("FAIL flush_r5_read got v=%0b in0=%h exp 1/0000", out_valid, alu_in0); end
      idle();
      // Write-back to r0 in the same cycle as a read of r0: no bypass.
      wb_en = 1'b1; wb_addr = 3'd0; wb_data = 16'hBEEF;
      instr(4'b0000, 3'd0, 3'd0, 3'd0, 8'd0, 1'b0);
      step();
      tests++;
      if (alu_in0 !== 16'h0000 || alu_in1 !== 16'h0000) begin fails++; $display("FAIL r0_bypass got in0=%h in1=%h exp 0/0", alu_in0, alu_in1); end
      wb_en = 1'b0;
      step();
      tests++;
      if (alu_in0 !== 16'h0000) begin fails++; $display("FAIL r0_write got %h exp 0000", alu_in0); end
      idle(); step();
   endtask

   task automatic test_back_to_back();
      logic [2:0]  rs_v [3];
      logic [15:0] exp_v [3];
      rs_v[0] = 3'd3; rs_v[1] = 3'd2; rs_v[2] = 3'd0;
      exp_v[0] = 16'h1234; exp_v[1] = 16'h00FF; exp_v[2] = 16'h0000;
      out_ready = 1'b1;
      for (int i = 0; i < 3; i++) begin
         instr(4'(i + 1), 3'd0, rs_v[i], 3'd0, 8'd0, 1'b0);
         #1;
         tests++;
         if (in_ready !== 1'b1) begin fails++; $display("FAIL b2b_ready%0d got %0b exp 1", i, in_ready); end
         step();
         tests++;
         if (out_valid !== 1'b1 || alu_in0 !== exp_v[i] || alu_select !== 4'(i + 1)) begin
            fails++; $display("FAIL b2b_out%0d got v=%0b in0=%h sel=%h exp 1/%h/%h", i, out_valid, alu_in0, alu_select, exp_v[i], 4'(i + 1));
         end
      end
      idle(); step();
      tests++;
      if (out_valid !== 1'b0) begin fails++; $display("FAIL b2b_drain got %0b exp 0", out_valid); end
   endtask

   task automatic test_midreset();
      instr(4'b0000, 3'd6, 3'd0, 3'd0, 8'd0, 1'b0);
      step();
      idle();
      rst_n = 1'b0;
      #1;
      tests++;
      if (out_valid !== 1'b0 || alu_wr !== 1'b0 || alu_rd !== 3'd0) begin
         fails++; $display("FAIL midreset_bundle got v=%0b wr=%0b rd=%0d exp 0/0/0", out_valid, alu_wr, alu_rd);
      end
      step();
      rst_n = 1'b1;
      step();
      instr(4'b0000, 3'd0, 3'd6, 3'd3, 8'd0, 1'b0);
      #1;
      tests++;
      if (in_ready !== 1'b1) begin fails++; $display("FAIL midreset_pending got %0b exp 1", in_ready); end
      step();
      tests++;
      if (alu_in1 !== 16'h0000) begin fails++; $display("FAIL midreset_regs got %h exp 0000", alu_in1); end
      idle(); step();
   endtask

   initial begin
      idle();
      out_ready = 1'b1;
      rst_n = 1'b1;
      #2;
      test_reset();
      test_basic();
      test_hazard();
      test_imm();
      test_backpressure();
      test_flush();
      test_back_to_back();
      test_midreset();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
